// File: rtl/rs_branch_q_pkg.sv
// Shared defaults and branch-condition encodings for the branch reservation queue.
package rs_branch_q_pkg;

    localparam int DEPTH_DEFAULT  = 16;
    localparam int NUM_WB_DEFAULT = 4;
    localparam int XLEN_DEFAULT   = 32;
    localparam int PTAG_W_DEFAULT = 8;

    // RISC-V branch funct3 encodings carried through the queue untouched
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

endpackage

// File: rtl/rs_wakeup_match.sv
// Compares one waiting source tag against every result broadcast port.
// Lowest port index wins when several ports carry the same tag; tag 0 is
// the hard-wired zero register and is never woken.
module rs_wakeup_match
    import rs_branch_q_pkg::*;
#(
    parameter int NUM_WB = NUM_WB_DEFAULT,
    parameter int PTAG_W = PTAG_W_DEFAULT,
    parameter int XLEN   = XLEN_DEFAULT
) (
    input  logic [PTAG_W-1:0]        tag,
    input  logic                     rdy,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PTAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    // Scan ports from highest to lowest so the lowest matching index lands last
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (!rdy && (tag != '0) && wb_valid[p] &&
                (wb_tag[p*PTAG_W +: PTAG_W] == tag)) begin
                hit  = 1'b1;
                data = wb_data[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rs_branch_q.sv
// In-order branch reservation queue: circular FIFO of branch/jump entries that
// wait for their two source operands, then issue from the head into a
// registered output stage with a valid/ready handshake.
module rs_branch_q
    import rs_branch_q_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int NUM_WB = NUM_WB_DEFAULT,
    parameter int PTAG_W = PTAG_W_DEFAULT,
    parameter int XLEN   = XLEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst_num,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [PTAG_W-1:0]          in_rd,
    input  logic                       in_jump,
    input  logic                       in_branch,
    input  logic                       in_pred_taken,
    input  logic                       in_pred_hit,
    input  logic [2:0]                 in_funct3,
    input  logic [PTAG_W-1:0]          in_src1_tag,
    input  logic [PTAG_W-1:0]          in_src2_tag,
    input  logic [XLEN-1:0]            in_src1_data,
    input  logic [XLEN-1:0]            in_src2_data,
    input  logic                       in_src1_rdy,
    input  logic                       in_src2_rdy,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*PTAG_W-1:0]   wb_tag,
    input  logic [NUM_WB*XLEN-1:0]     wb_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst_num,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_imm,
    output logic [PTAG_W-1:0]          out_rd,
    output logic                       out_jump,
    output logic                       out_branch,
    output logic                       out_pred_taken,
    output logic                       out_pred_hit,
    output logic [2:0]                 out_funct3,
    output logic [XLEN-1:0]            out_op1,
    output logic [XLEN-1:0]            out_op2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue storage; only the ready bits are control state
    logic [31:0]       inst_num_q  [DEPTH];
    logic [XLEN-1:0]   pc_q        [DEPTH];
    logic [XLEN-1:0]   imm_q       [DEPTH];
    logic [PTAG_W-1:0] rd_q        [DEPTH];
    logic [DEPTH-1:0]  jump_q;
    logic [DEPTH-1:0]  branch_q;
    logic [DEPTH-1:0]  pred_taken_q;
    logic [DEPTH-1:0]  pred_hit_q;
    logic [2:0]        funct3_q    [DEPTH];
    logic [PTAG_W-1:0] src1_tag_q  [DEPTH];
    logic [PTAG_W-1:0] src2_tag_q  [DEPTH];
    logic [XLEN-1:0]   src1_data_q [DEPTH];
    logic [XLEN-1:0]   src2_data_q [DEPTH];
    logic [DEPTH-1:0]  src1_rdy_q;
    logic [DEPTH-1:0]  src2_rdy_q;

    logic [AW-1:0]     head_q;
    logic [AW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic              enq;
    logic              issue;

    logic              enq1_hit;
    logic              enq2_hit;
    logic [XLEN-1:0]   enq1_wb_data;
    logic [XLEN-1:0]   enq2_wb_data;
    logic              enq1_rdy;
    logic              enq2_rdy;
    logic [XLEN-1:0]   enq1_data;
    logic [XLEN-1:0]   enq2_data;

    logic [DEPTH-1:0]  e1_hit;
    logic [DEPTH-1:0]  e2_hit;
    logic [XLEN-1:0]   e1_data [DEPTH];
    logic [XLEN-1:0]   e2_data [DEPTH];

    assign in_ready = (count_q < CW'(DEPTH));
    assign count    = count_q;
    assign enq      = in_valid && in_ready && !flush;
    // Issue looks only at registered readiness; a same-cycle wakeup waits a cycle
    assign issue    = !flush && (count_q != '0) && src1_rdy_q[head_q] &&
                      src2_rdy_q[head_q] && (!out_valid || out_ready);

    // Enqueue-path bypass: each incoming source checks the bus on its own
    rs_wakeup_match #(.NUM_WB(NUM_WB), .PTAG_W(PTAG_W), .XLEN(XLEN)) u_enq_src1 (
        .tag(in_src1_tag), .rdy(in_src1_rdy), .wb_valid(wb_valid),
        .wb_tag(wb_tag), .wb_data(wb_data), .hit(enq1_hit), .data(enq1_wb_data)
    );

    rs_wakeup_match #(.NUM_WB(NUM_WB), .PTAG_W(PTAG_W), .XLEN(XLEN)) u_enq_src2 (
        .tag(in_src2_tag), .rdy(in_src2_rdy), .wb_valid(wb_valid),
        .wb_tag(wb_tag), .wb_data(wb_data), .hit(enq2_hit), .data(enq2_wb_data)
    );

    // Resolve incoming operands: already ready, bypassed from wb, or tag 0 = zero
    always_comb begin
        enq1_rdy  = in_src1_rdy || enq1_hit || (in_src1_tag == '0);
        enq2_rdy  = in_src2_rdy || enq2_hit || (in_src2_tag == '0);
        enq1_data = in_src1_data;
        enq2_data = in_src2_data;
        if (!in_src1_rdy) begin
            if (enq1_hit) begin
                enq1_data = enq1_wb_data;
            end else if (in_src1_tag == '0) begin
                enq1_data = '0;
            end
        end
        if (!in_src2_rdy) begin
            if (enq2_hit) begin
                enq2_data = enq2_wb_data;
            end else if (in_src2_tag == '0) begin
                enq2_data = '0;
            end
        end
    end

    // Per-entry wakeup comparators for both sources
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_match
        rs_wakeup_match #(.NUM_WB(NUM_WB), .PTAG_W(PTAG_W), .XLEN(XLEN)) u_src1 (
            .tag(src1_tag_q[i]), .rdy(src1_rdy_q[i]), .wb_valid(wb_valid),
            .wb_tag(wb_tag), .wb_data(wb_data), .hit(e1_hit[i]), .data(e1_data[i])
        );
        rs_wakeup_match #(.NUM_WB(NUM_WB), .PTAG_W(PTAG_W), .XLEN(XLEN)) u_src2 (
            .tag(src2_tag_q[i]), .rdy(src2_rdy_q[i]), .wb_valid(wb_valid),
            .wb_tag(wb_tag), .wb_data(wb_data), .hit(e2_hit[i]), .data(e2_data[i])
        );
    end

    // Pointers, occupancy and operand ready bits; flush squashes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + AW'(1);
            end
            if (issue) begin
                head_q <= head_q + AW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(issue);
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && (tail_q == AW'(i))) begin
                    src1_rdy_q[i] <= enq1_rdy;
                    src2_rdy_q[i] <= enq2_rdy;
                end else begin
                    if (e1_hit[i]) src1_rdy_q[i] <= 1'b1;
                    if (e2_hit[i]) src2_rdy_q[i] <= 1'b1;
                end
            end
        end
    end

    // Entry payload: written on enqueue, operand data captured on wakeup
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (tail_q == AW'(i))) begin
                inst_num_q[i]   <= in_inst_num;
                pc_q[i]         <= in_pc;
                imm_q[i]        <= in_imm;
                rd_q[i]         <= in_rd;
                jump_q[i]       <= in_jump;
                branch_q[i]     <= in_branch;
                pred_taken_q[i] <= in_pred_taken;
                pred_hit_q[i]   <= in_pred_hit;
                funct3_q[i]     <= in_funct3;
                src1_tag_q[i]   <= in_src1_tag;
                src2_tag_q[i]   <= in_src2_tag;
                src1_data_q[i]  <= enq1_data;
                src2_data_q[i]  <= enq2_data;
            end else if (!flush) begin
                if (e1_hit[i]) src1_data_q[i] <= e1_data[i];
                if (e2_hit[i]) src2_data_q[i] <= e2_data[i];
            end
        end
    end

    // Output register: loads the head on issue, holds while stalled downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_inst_num   <= '0;
            out_pc         <= '0;
            out_imm        <= '0;
            out_rd         <= '0;
            out_jump       <= 1'b0;
            out_branch     <= 1'b0;
            out_pred_taken <= 1'b0;
            out_pred_hit   <= 1'b0;
            out_funct3     <= '0;
            out_op1        <= '0;
            out_op2        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid      <= 1'b1;
            out_inst_num   <= inst_num_q[head_q];
            out_pc         <= pc_q[head_q];
            out_imm        <= imm_q[head_q];
            out_rd         <= rd_q[head_q];
            out_jump       <= jump_q[head_q];
            out_branch     <= branch_q[head_q];
            out_pred_taken <= pred_taken_q[head_q];
            out_pred_hit   <= pred_hit_q[head_q];
            out_funct3     <= funct3_q[head_q];
            out_op1        <= src1_data_q[head_q];
            out_op2        <= src2_data_q[head_q];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rs_branch_q.md
RS_BRANCH_Q -- requirements
Module: rs_branch_q

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter NUM_WB, default 4, number of wakeup (result broadcast) ports.
REQ-003 Parameter PTAG_W, default 8, physical register tag width.
REQ-004 Parameter XLEN, default 32, data, PC and immediate width.
REQ-005 Port clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port in_valid / in_ready  in / out  1 / 1  enqueue handshake.
REQ-008 Port in_inst_num, in_pc, in_imm  in  32 / XLEN / XLEN  instruction id, PC, immediate.
REQ-009 Port in_rd  in  PTAG_W  destination tag.
REQ-010 Port in_jump, in_branch, in_pred_taken, in_pred_hit  in  1 each  type and prediction bits.
REQ-011 Port in_funct3  in  3  branch condition.
REQ-012 Port in_src1_tag, in_src2_tag  in  PTAG_W each  source tags.
REQ-013 Port in_src1_data, in_src2_data  in  XLEN each  source values.
REQ-014 Port in_src1_rdy, in_src2_rdy  in  1 each  source value already valid.
REQ-015 Port wb_valid, wb_tag, wb_data  in  NUM_WB / NUM_WB*PTAG_W / NUM_WB*XLEN  packed wakeup ports.
REQ-016 Port flush  in  1  mispredict squash of all held entries.
REQ-017 Port out_valid / out_ready  out / in  1 / 1  issue handshake.
REQ-018 Port out_inst_num, out_pc, out_imm, out_rd, out_jump, out_branch, out_pred_taken, out_pred_hit, out_funct3, out_op1, out_op2  out  widths per REQ-008..013  issued entry.
REQ-019 Port count  out  $clog2(DEPTH)+1  occupied entries, excluding the output register.

Function
REQ-020 Queue SHALL be a circular FIFO; head/tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 in_ready SHALL be (count < DEPTH); a dequeue in the same cycle SHALL NOT raise in_ready.
REQ-022 Enqueue SHALL occur when in_valid && in_ready && !flush; the entry is written at tail.
REQ-023 Enqueue bypass: a source with rdy=0 matching any same-cycle wb_valid port SHALL be stored ready with that wb_data; src1 and src2 SHALL be resolved independently, unlike a single-match priority chain.
REQ-024 Wakeup: every held entry source with ready=0 and tag equal to a valid wb_tag SHALL capture wb_data and set ready.
REQ-025 If several ports match one source, the lowest port index SHALL win.
REQ-026 Tag 0 SHALL never be woken by wb; a source with tag 0 enqueued not ready SHALL be stored ready with data 0.
REQ-027 Issue SHALL be strictly in order from head: the head entry issues when both sources are ready and (!out_valid || out_ready).
REQ-028 Readiness SHALL be taken from registered state, so the earliest issue after a wakeup is the following cycle; issue-to-out_valid latency is 1 cycle.
REQ-029 An empty queue SHALL never issue, including in the cycle of the first enqueue.
REQ-030 Output register SHALL hold all out_* values stable while out_valid && !out_ready.
REQ-031 out_valid SHALL drop after an accepted transfer when no new issue occurs.
REQ-032 Simultaneous enqueue and issue SHALL leave count unchanged.
REQ-033 flush SHALL, next edge, zero count, head and tail and clear out_valid; flush SHALL override enqueue, issue and wakeup.
REQ-034 Wakeup data arriving in the flush cycle SHALL be discarded.

Reset
REQ-035 reset SHALL asynchronously clear head, tail, count, all entry ready bits and out_valid.
REQ-036 reset SHALL clear all out_* data outputs to 0.
REQ-037 in_ready SHALL be 1 while reset is deasserted and the queue is empty.
REQ-038 Reset asserted mid-operation SHALL drop all entries with no issue.

Structure
REQ-039 A shared package SHALL hold the default XLEN, PTAG_W and funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-040 One sub-module, rs_wakeup_match, SHALL take a tag and ready bit plus the wb bus and return a hit bit and data; it SHALL be instantiated for the enqueue path and for each entry source.

Verification
REQ-041 Enqueue with both sources ready -> out_valid in the second cycle after the enqueue edge, op1/op2 equal to inputs.
REQ-042 Enqueue src1_tag=5 not ready; wb port 2 tag=5, data=0xDEADBEEF three cycles later -> out_op1=0xDEADBEEF, issue exactly 1 cycle after the wakeup.
REQ-043 Enqueue src2_tag=7 with same-cycle wb tag 7 -> stored ready, no waiting; separately, ports 0 and 3 both carrying tag 9 -> port 0 data is captured.
REQ-044 Fill DEPTH=4 entries, head not ready -> in_ready=0 and count=4; younger ready entries SHALL NOT issue; after the head wakeup, entries drain in order 0,1,2,3 with pointer wrap verified.
REQ-045 Hold out_ready=0 for 5 cycles with ready entries behind -> outputs stable, no entry lost; on release, back-to-back issue at one entry per cycle.
REQ-046 flush together with in_valid and wb_valid while count=3 -> count=0 and out_valid=0 next cycle; asynchronous reset pulse between edges -> immediate clear.
